// File: rtl/sdram_access_arbiter.sv
// SDRAM command-bus arbiter: shares the bus between the write path, the read
// path and the periodic auto-refresh. Owns the refresh interval timer and
// issues the precharge-all / auto-refresh sequence itself.
//
// Handshake: a path raises its req and holds it for the whole burst; the
// arbiter answers with a registered grant one cycle after sampling req in
// IDLE, keeps the grant while req stays high, and drops it the cycle after
// req is sampled low. o_refresh asks the owner to end its burst early; the
// arbiter never takes the bus away from a path that still holds req.
module sdram_access_arbiter #(
    parameter int T_AR_TIMEOUT = 1500,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int REF_SLACK    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init_done,
    input  logic        i_wr_req,
    output logic        o_wr_grant,
    input  logic        i_rd_req,
    output logic        o_rd_grant,
    output logic        o_refresh,
    output logic        o_ref_active,
    output logic [2:0]  o_cmd,
    output logic        o_addr10,
    output logic        o_ref_late,
    output logic [15:0] o_ref_count,
    output logic [2:0]  dbg_state
);

    localparam int TIMER_W  = $clog2(T_AR_TIMEOUT + 1);
    localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int LATE_W   = $clog2(REF_SLACK + 2);

    // {ras, cas, we}, active low
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(T_AR_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT_WR,
        ST_GRANT_RD,
        ST_REF_PRE,
        ST_REF_PRE_WAIT,
        ST_REF_AR,
        ST_REF_AR_WAIT
    } state_t;

    typedef enum logic {
        PATH_WR,
        PATH_RD
    } path_t;

    state_t              state;
    path_t               last_grant;
    logic [TIMER_W-1:0]  timer;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [LATE_W-1:0]   late_cnt;
    logic                ref_done;

    // The refresh sequence ends on the last REF_AR_WAIT cycle.
    assign ref_done  = (state == ST_REF_AR_WAIT) && (wait_cnt == '0);
    assign dbg_state = state;

    // Arbitration FSM, refresh interval timer and refresh command sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= PATH_RD;
            timer        <= TIMER_RELOAD;
            wait_cnt     <= '0;
            o_wr_grant   <= 1'b0;
            o_rd_grant   <= 1'b0;
            o_refresh    <= 1'b0;
            o_ref_active <= 1'b0;
            o_cmd        <= CMD_NOP;
            o_addr10     <= 1'b0;
            o_ref_count  <= '0;
        end else if (!i_init_done) begin
            // SDRAM not ready: arbiter stays inert with the timer parked.
            state        <= ST_IDLE;
            timer        <= TIMER_RELOAD;
            wait_cnt     <= '0;
            o_wr_grant   <= 1'b0;
            o_rd_grant   <= 1'b0;
            o_refresh    <= 1'b0;
            o_ref_active <= 1'b0;
            o_cmd        <= CMD_NOP;
            o_addr10     <= 1'b0;
        end else begin
            // Timer counts down to zero, raises the pending flag and then
            // parks at zero until the refresh sequence reloads it.
            if (timer != '0) begin
                timer <= timer - 1'b1;
                if (timer == TIMER_W'(1)) begin
                    o_refresh <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (o_refresh) begin
                        state        <= ST_REF_PRE;
                        o_ref_active <= 1'b1;
                        o_cmd        <= CMD_PRE;
                        o_addr10     <= 1'b1;
                    end else if (i_wr_req && (!i_rd_req || last_grant == PATH_RD)) begin
                        state      <= ST_GRANT_WR;
                        o_wr_grant <= 1'b1;
                        last_grant <= PATH_WR;
                    end else if (i_rd_req) begin
                        state      <= ST_GRANT_RD;
                        o_rd_grant <= 1'b1;
                        last_grant <= PATH_RD;
                    end
                end
                ST_GRANT_WR: begin
                    if (!i_wr_req) begin
                        state      <= ST_IDLE;
                        o_wr_grant <= 1'b0;
                    end
                end
                ST_GRANT_RD: begin
                    if (!i_rd_req) begin
                        state      <= ST_IDLE;
                        o_rd_grant <= 1'b0;
                    end
                end
                ST_REF_PRE: begin
                    state    <= ST_REF_PRE_WAIT;
                    o_cmd    <= CMD_NOP;
                    o_addr10 <= 1'b0;
                    wait_cnt <= WAIT_W'(T_RP - 1);
                end
                ST_REF_PRE_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_REF_AR;
                        o_cmd <= CMD_AR;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_REF_AR: begin
                    state    <= ST_REF_AR_WAIT;
                    o_cmd    <= CMD_NOP;
                    wait_cnt <= WAIT_W'(T_RFC - 1);
                end
                ST_REF_AR_WAIT: begin
                    if (wait_cnt == '0) begin
                        state        <= ST_IDLE;
                        o_ref_active <= 1'b0;
                        o_refresh    <= 1'b0;
                        timer        <= TIMER_RELOAD;
                        o_ref_count  <= o_ref_count + 16'd1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_wr_grant   <= 1'b0;
                    o_rd_grant   <= 1'b0;
                    o_ref_active <= 1'b0;
                    o_cmd        <= CMD_NOP;
                    o_addr10     <= 1'b0;
                end
            endcase
        end
    end

    // Late monitor: counts pending cycles (saturating) and latches the sticky
    // late flag once a refresh has waited longer than REF_SLACK cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            late_cnt   <= '0;
            o_ref_late <= 1'b0;
        end else if (!i_init_done) begin
            late_cnt <= '0;
        end else begin
            if (o_refresh) begin
                if (late_cnt == LATE_W'(REF_SLACK)) begin
                    o_ref_late <= 1'b1;
                end else begin
                    late_cnt <= late_cnt + 1'b1;
                end
            end
            if (ref_done) begin
                late_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: directed scenarios plus randomized request
// traffic, every cycle compared against a transaction-level model of the
// arbitration and refresh rules.
module tb_sdram_access_arbiter;

  localparam int T_AR    = 100;
  localparam int TRP     = 2;
  localparam int TRFC    = 7;
  localparam int SLACK   = 20;
  localparam int SLACK_B = 64;
  localparam int REF_LEN = 2 + TRP + TRFC;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_AR  = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic init_done;
  logic wr_req;
  logic rd_req;

  always #5 clk = ~clk;

  logic        wr_grant, rd_grant, refresh, ref_active, addr10, ref_late;
  logic [2:0]  cmd;
  logic [15:0] ref_count;
  logic [2:0]  dbg_state;

  logic        b_wr_grant, b_rd_grant, b_refresh, b_ref_active, b_addr10, b_ref_late;
  logic [2:0]  b_cmd;
  logic [15:0] b_ref_count;
  logic [2:0]  b_dbg_state;

  sdram_access_arbiter #(
    .T_AR_TIMEOUT(T_AR), .T_RP(TRP), .T_RFC(TRFC), .REF_SLACK(SLACK)
  ) dut (
    .clk(clk), .rst(rst), .i_init_done(init_done),
    .i_wr_req(wr_req), .o_wr_grant(wr_grant),
    .i_rd_req(rd_req), .o_rd_grant(rd_grant),
    .o_refresh(refresh), .o_ref_active(ref_active),
    .o_cmd(cmd), .o_addr10(addr10), .o_ref_late(ref_late),
    .o_ref_count(ref_count), .dbg_state(dbg_state)
  );

  // Same traffic, wider slack: only its late flag is of interest.
  sdram_access_arbiter #(
    .T_AR_TIMEOUT(T_AR), .T_RP(TRP), .T_RFC(TRFC), .REF_SLACK(SLACK_B)
  ) dut_b (
    .clk(clk), .rst(rst), .i_init_done(init_done),
    .i_wr_req(wr_req), .o_wr_grant(b_wr_grant),
    .i_rd_req(rd_req), .o_rd_grant(b_rd_grant),
    .o_refresh(b_refresh), .o_ref_active(b_ref_active),
    .o_cmd(b_cmd), .o_addr10(b_addr10), .o_ref_late(b_ref_late),
    .o_ref_count(b_ref_count), .dbg_state(b_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = write path, 2 = read path
  int          m_owner;
  int          m_last;
  bit          m_in_ref;
  int          m_ref_pos;     // cycle index inside the refresh sequence
  int          m_timer;
  bit          m_pending;
  int          m_pend_cycles;
  bit          m_late_a;
  bit          m_late_b;
  logic [15:0] m_count;
  logic [1:0]  exp_q[$];      // expected order of grants
  logic [1:0]  obs_order[$];
  bit          prev_wr, prev_rd;

  task automatic model_reset();
    m_owner       = 0;
    m_last        = 2;
    m_in_ref      = 1'b0;
    m_ref_pos     = 0;
    m_timer       = T_AR;
    m_pending     = 1'b0;
    m_pend_cycles = 0;
    m_late_a      = 1'b0;
    m_late_b      = 1'b0;
    m_count       = 16'd0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit nxt_pending;
    if (rst) begin
      model_reset();
      return;
    end
    if (!init_done) begin
      m_owner       = 0;
      m_in_ref      = 1'b0;
      m_ref_pos     = 0;
      m_timer       = T_AR;
      m_pending     = 1'b0;
      m_pend_cycles = 0;
      return;
    end
    nxt_pending = m_pending;
    if (m_pending) begin
      m_pend_cycles++;
      if (m_pend_cycles > SLACK)   m_late_a = 1'b1;
      if (m_pend_cycles > SLACK_B) m_late_b = 1'b1;
    end
    if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) nxt_pending = 1'b1;
    end
    if (m_in_ref) begin
      m_ref_pos++;
      if (m_ref_pos == REF_LEN) begin
        m_in_ref      = 1'b0;
        nxt_pending   = 1'b0;
        m_timer       = T_AR;
        m_pend_cycles = 0;
        m_count       = m_count + 16'd1;
      end
    end else if (m_owner == 1) begin
      if (!wr_req) m_owner = 0;
    end else if (m_owner == 2) begin
      if (!rd_req) m_owner = 0;
    end else if (m_pending) begin
      m_in_ref  = 1'b1;
      m_ref_pos = 0;
    end else if (wr_req && (!rd_req || m_last == 2)) begin
      m_owner = 1;
      m_last  = 1;
      exp_q.push_back(2'd1);
    end else if (rd_req) begin
      m_owner = 2;
      m_last  = 2;
      exp_q.push_back(2'd2);
    end
    m_pending = nxt_pending;
  endtask

  // Compare every output of the DUT against the model.
  task automatic compare_all();
    logic [2:0] e_cmd;
    logic [1:0] e_path;
    e_cmd = CMD_NOP;
    if (m_in_ref && m_ref_pos == 0)       e_cmd = CMD_PRE;
    if (m_in_ref && m_ref_pos == 1 + TRP) e_cmd = CMD_AR;
    check("wr_grant",   32'(wr_grant),   32'(m_owner == 1));
    check("rd_grant",   32'(rd_grant),   32'(m_owner == 2));
    check("refresh",    32'(refresh),    32'(m_pending));
    check("ref_active", 32'(ref_active), 32'(m_in_ref));
    check("cmd",        32'(cmd),        32'(e_cmd));
    check("addr10",     32'(addr10),     32'(m_in_ref && m_ref_pos == 0));
    check("ref_late",   32'(ref_late),   32'(m_late_a));
    check("ref_count",  32'(ref_count),  32'(m_count));
    check("late_slack64", 32'(b_ref_late), 32'(m_late_b));
    check("exclusive",  32'({wr_grant & rd_grant, wr_grant & ref_active, rd_grant & ref_active}), 32'(0));
    if (wr_grant && !prev_wr) begin
      e_path = 2'd0;
      if (exp_q.size() > 0) e_path = exp_q.pop_front();
      obs_order.push_back(2'd1);
      check("grant_order", 32'(2'd1), 32'(e_path));
    end
    if (rd_grant && !prev_rd) begin
      e_path = 2'd0;
      if (exp_q.size() > 0) e_path = exp_q.pop_front();
      obs_order.push_back(2'd2);
      check("grant_order", 32'(2'd2), 32'(e_path));
    end
    prev_wr = wr_grant;
    prev_rd = rd_grant;
  endtask

  // ---------------- driver ----------------
  bit agent_en = 1'b0;
  int burst_min, burst_max, gap_min, gap_max;
  int wr_hold, wr_gap, rd_hold, rd_gap;

  // Request agents: hold req for a burst once granted, then idle for a gap.
  task automatic drive_agents();
    if (!agent_en) return;
    if (wr_req) begin
      if (m_owner == 1) begin
        if (wr_hold == 0) begin
          wr_req = 1'b0;
          wr_gap = $urandom_range(gap_max, gap_min);
        end else wr_hold--;
      end
    end else if (wr_gap == 0) begin
      wr_req  = 1'b1;
      wr_hold = $urandom_range(burst_max, burst_min);
    end else wr_gap--;
    if (rd_req) begin
      if (m_owner == 2) begin
        if (rd_hold == 0) begin
          rd_req = 1'b0;
          rd_gap = $urandom_range(gap_max, gap_min);
        end else rd_hold--;
      end
    end else if (rd_gap == 0) begin
      rd_req  = 1'b1;
      rd_hold = $urandom_range(burst_max, burst_min);
    end else rd_gap--;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_agents();
  endtask

  // Cycles from now until o_refresh rises (bounded).
  task automatic measure_interval(input string tag);
    int n;
    n = 0;
    while (!refresh && n < 3 * T_AR) begin
      cycle();
      n++;
    end
    check(tag, 32'(n), 32'(T_AR));
  endtask

  task automatic wait_grant(input string tag, input int path);
    int n;
    n = 0;
    while (m_owner != path && n < 60) begin
      cycle();
      n++;
    end
    check(tag, 32'(path == 1 ? wr_grant : rd_grant), 32'(1));
  endtask

  task automatic wait_refresh(input string tag);
    int n;
    n = 0;
    while (!refresh && n < 3 * T_AR) begin
      cycle();
      n++;
    end
    check(tag, 32'(refresh), 32'(1));
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_wr_grant"},  32'(wr_grant),   32'(0));
    check({tag, "_rd_grant"},  32'(rd_grant),   32'(0));
    check({tag, "_cmd"},       32'(cmd),        32'(CMD_NOP));
    check({tag, "_ref_count"}, 32'(ref_count),  32'(0));
    check({tag, "_ref_active"}, 32'(ref_active), 32'(0));
    check({tag, "_refresh"},   32'(refresh),    32'(0));
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int init_off;
    rst = 1'b1;
    init_done = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_cmd",       32'(cmd),        32'(CMD_NOP));
    check("reset_wr_grant",  32'(wr_grant),   32'(0));
    check("reset_rd_grant",  32'(rd_grant),   32'(0));
    check("reset_refresh",   32'(refresh),    32'(0));
    check("reset_ref_count", 32'(ref_count),  32'(0));
    check("reset_ref_late",  32'(ref_late),   32'(0));
    compare_all();
    rst = 1'b0;
    repeat (5) cycle();

    // Refresh only: interval, sequence and count.
    init_done = 1'b1;
    measure_interval("t1_interval");
    repeat (30) cycle();
    check("t1_ref_count", 32'(ref_count), 32'(1));

    // Both paths requesting: round-robin WR, RD, WR.
    obs_order.delete();
    burst_min = 9; burst_max = 9; gap_min = 0; gap_max = 0;
    wr_gap = 0; rd_gap = 0;
    agent_en = 1'b1;
    repeat (45) cycle();
    agent_en = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (3) cycle();
    check("t2_order_len", 32'(obs_order.size() >= 3), 32'(1));
    check("t2_order0", 32'(obs_order[0]), 32'(1));
    check("t2_order1", 32'(obs_order[1]), 32'(2));
    check("t2_order2", 32'(obs_order[2]), 32'(1));

    // Owner ignores refresh: late flag and its stickiness.
    wr_req = 1'b1;
    wait_grant("t4_wr_grant", 1);
    wait_refresh("t4_refresh");
    n = 0;
    while (!ref_late && n < 60) begin
      cycle();
      n++;
    end
    check("t4_late_delay", 32'(n), 32'(SLACK + 1));
    repeat (40 - SLACK - 1) cycle();
    wr_req = 1'b0;
    repeat (20) cycle();
    check("t4_late_sticky", 32'(ref_late), 32'(1));
    check("t4_late64_clear", 32'(b_ref_late), 32'(0));

    // Async reset mid-grant and mid-REF_AR_WAIT.
    wr_req = 1'b1;
    wait_grant("t5_wr_grant", 1);
    repeat (3) cycle();
    wr_req = 1'b0;
    async_reset("t5a");
    measure_interval("t5_interval");
    n = 0;
    while (!(m_in_ref && m_ref_pos >= 2 + TRP) && n < 30) begin
      cycle();
      n++;
    end
    check("t5_in_ar_wait", 32'(ref_active && cmd == CMD_NOP), 32'(1));
    async_reset("t5b");

    // Read owner holds through a pending refresh.
    rd_req = 1'b1;
    wait_grant("t3_rd_grant", 2);
    wait_refresh("t3_refresh");
    repeat (30) cycle();
    check("t3_grant_kept", 32'(rd_grant), 32'(1));
    rd_req = 1'b0;
    n = 0;
    while (cmd != CMD_PRE && n < 10) begin
      cycle();
      n++;
    end
    check("t3_pre_delay", 32'(n), 32'(2));
    repeat (15) cycle();
    check("t3_late64", 32'(b_ref_late), 32'(0));

    // Init dropped during a write grant.
    wr_req = 1'b1;
    wait_grant("t6_wr_grant", 1);
    init_done = 1'b0;
    cycle();
    check("t6_grant_drop", 32'(wr_grant), 32'(0));
    check("t6_refresh_clear", 32'(refresh), 32'(0));
    repeat (4) cycle();
    wr_req = 1'b0;
    init_done = 1'b1;
    measure_interval("t6_interval");

    // Randomized traffic with occasional init drops.
    burst_min = 0; burst_max = 25; gap_min = 0; gap_max = 12;
    wr_gap = $urandom_range(5, 0);
    rd_gap = $urandom_range(5, 0);
    init_off = 0;
    agent_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (init_off > 0) begin
        init_off--;
        if (init_off == 0) init_done = 1'b1;
      end else if ($urandom_range(299, 0) == 0) begin
        init_done = 1'b0;
        init_off = $urandom_range(4, 1);
      end
    end
    agent_en = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    init_done = 1'b1;
    repeat (20) cycle();
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Shares the SDRAM command bus between the write path, the read path and the periodic auto-refresh.
- Owns the refresh interval timer and issues the refresh sequence itself: precharge-all, then auto-refresh.
- Grants are exclusive. The owning path's command/address are muxed onto the pins downstream by the top-level on grant.
- Runs in the SDRAM clock domain and starts after initialisation completes.

Parameters:
T_AR_TIMEOUT, 1500, cycles between refresh requests; the timer reloads after each refresh.
T_RP, 2, NOP cycles after precharge-all.
T_RFC, 7, NOP cycles after auto-refresh.
REF_SLACK, 64, cycles a refresh may stay pending before the late flag sets.

Ports:
clk  in  1  SDRAM clock
rst  in  1  asynchronous, active-high reset
i_init_done  in  1  SDRAM init sequence finished; arbiter is inert while low
i_wr_req  in  1  write path requests the bus; held until its burst ends
o_wr_grant  out  1  write path owns the bus
i_rd_req  in  1  read path requests the bus
o_rd_grant  out  1  read path owns the bus
o_refresh  out  1  refresh pending; the owner must drop req at its next burst boundary
o_ref_active  out  1  arbiter drives the command bus (refresh sequence)
o_cmd  out  3  {ras,cas,we}, active-low: NOP 3'b111, PRE 3'b010, AR 3'b001
o_addr10  out  1  A10; 1 during PRE (all banks)
o_ref_late  out  1  sticky: a refresh waited more than REF_SLACK cycles
o_ref_count  out  16  refreshes completed; wraps at 16'hFFFF->0

Behaviour:
- Reset (async): state IDLE; all grants 0; o_refresh 0; o_ref_active 0; o_cmd NOP; o_addr10 0; o_ref_late 0; o_ref_count 0; timer = T_AR_TIMEOUT; last_grant = RD.
- Reset mid-burst drops the grant immediately. No recovery command is issued.
- i_init_done low (synchronous): forces IDLE, grants 0, timer held at reload, pending cleared.
- Timer: decrements every cycle while i_init_done. At 0 it sets pending (o_refresh=1) and holds at 0 until the refresh completes, then reloads.
- States: IDLE, GRANT_WR, GRANT_RD, REF_PRE, REF_PRE_WAIT, REF_AR, REF_AR_WAIT.
- IDLE priority: pending refresh > requests.
  - pending -> REF_PRE.
  - else wr-only -> GRANT_WR; rd-only -> GRANT_RD.
  - both -> the path not equal to last_grant (round-robin); last_grant updates on each grant.
- Grant latency: request sampled in IDLE; grant registered high the next cycle.
- GRANT_x: grant stays high while req high, regardless of o_refresh. When req is sampled low, grant goes 0 next cycle and the state returns to IDLE.
  - Minimum one IDLE cycle between grants, so grant is never handed directly between paths.
- REF_PRE: 1 cycle, o_cmd=PRE, o_addr10=1, o_ref_active=1. Then REF_PRE_WAIT for T_RP cycles with NOP.
- REF_AR: 1 cycle, o_cmd=AR. Then REF_AR_WAIT for T_RFC cycles with NOP.
- Leaving REF_AR_WAIT: pending clears, timer reloads, o_ref_count++, o_ref_active=0, state IDLE.
- Total refresh occupancy: 2+T_RP+T_RFC cycles.
- o_ref_active is high from REF_PRE through the last REF_AR_WAIT cycle. o_cmd is NOP whenever o_ref_active is 0.
- Requests arriving during a refresh are ignored until IDLE. A request held throughout is granted the cycle after IDLE.
- Late monitor: counts cycles while pending. Count > REF_SLACK sets o_ref_late (sticky until rst). The count clears when the refresh completes.
- Grants are mutually exclusive with each other and with o_ref_active in every cycle.

Test Plan:
1. T_AR_TIMEOUT=100, T_RP=2, T_RFC=7; no requests; release i_init_done → o_refresh at cycle 100 → PRE with A10=1 next cycle → 2 NOPs → AR → 7 NOPs → o_ref_count=1, timer reloads.
2. wr_req and rd_req asserted together and held 10 cycles each, then re-requested → order WR, RD, WR; one IDLE cycle between grants; grants never overlap.
3. rd granted; timer expires at cycle 100; rd holds req 30 more cycles → o_refresh high throughout, grant kept, PRE issued 2 cycles after req drops, o_ref_late stays 0.
4. REF_SLACK=20; owner ignores o_refresh for 40 cycles → o_ref_late sets at pending cycle 21 and stays 1 after the refresh completes.
5. Assert rst mid-grant and mid-REF_AR_WAIT → grants 0, o_cmd 3'b111, o_ref_count 0 in the same cycle (async); timer restarts at 100.
6. Drop i_init_done during GRANT_WR → grant 0 next cycle, o_refresh 0; restore → full 100-cycle interval before the next refresh.
